// File: rtl/masked_rca_if.sv
// masked_rca_if: operand/result bundle for the masked ripple-carry adder.
// Carries two Boolean shares per operand, carry-in, fresh randomness,
// and the registered (WIDTH+1)-bit result with its valid flag.
// Optional macro MASKED_SHARES_OUT_EN adds the registered result shares
// sum_s0/sum_s1 so downstream logic can stay in the masked domain.
// Ports (master drives, slave = adder):
//   in_valid, a0, a1, b0, b1, c_in, rnd  -> adder
//   sum, out_valid [, sum_s0, sum_s1]    <- adder
interface masked_rca_if #(
    parameter int WIDTH = 4
);
    logic                 in_valid;
    logic [WIDTH-1:0]     a0;
    logic [WIDTH-1:0]     a1;
    logic [WIDTH-1:0]     b0;
    logic [WIDTH-1:0]     b1;
    logic                 c_in;
    logic [2*WIDTH-1:0]   rnd;
    logic [WIDTH:0]       sum;
    logic                 out_valid;
`ifdef MASKED_SHARES_OUT_EN
    logic [WIDTH:0]       sum_s0;
    logic [WIDTH:0]       sum_s1;

    modport master (
        output in_valid, a0, a1, b0, b1, c_in, rnd,
        input  sum, out_valid, sum_s0, sum_s1
    );
    modport slave (
        input  in_valid, a0, a1, b0, b1, c_in, rnd,
        output sum, out_valid, sum_s0, sum_s1
    );
`else
    modport master (
        output in_valid, a0, a1, b0, b1, c_in, rnd,
        input  sum, out_valid
    );
    modport slave (
        input  in_valid, a0, a1, b0, b1, c_in, rnd,
        output sum, out_valid
    );
`endif
endinterface

// File: rtl/masked_rca.sv
// masked_rca: first-order Boolean-masked WIDTH-bit ripple-carry adder.
// Operands arrive as XOR shares; every AND term is refreshed with its own
// random bit (DOM form), shares are only recombined at the output register.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (clears sum, out_valid)
//   bus    masked_rca_if.slave: in_valid/a0/a1/b0/b1/c_in/rnd in,
//          sum (WIDTH+1, registered, 1-cycle latency)/out_valid out
// Optional macro MASKED_SHARES_OUT_EN: also registers the result shares
// onto bus.sum_s0/bus.sum_s1 (sum_s0 ^ sum_s1 == sum).
module masked_rca #(
    parameter int WIDTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    masked_rca_if.slave   bus
);

    logic [WIDTH-1:0]   a0;
    logic [WIDTH-1:0]   a1;
    logic [WIDTH-1:0]   b0;
    logic [WIDTH-1:0]   b1;
    logic [2*WIDTH-1:0] rnd;

    assign a0  = bus.a0;
    assign a1  = bus.a1;
    assign b0  = bus.b0;
    assign b1  = bus.b1;
    assign rnd = bus.rnd;

    // Propagate shares, AND-term shares and carry shares per bit.
    logic [WIDTH-1:0] p0;
    logic [WIDTH-1:0] p1;
    logic [WIDTH-1:0] ab0;
    logic [WIDTH-1:0] ab1;
    logic [WIDTH-1:0] cp0;
    logic [WIDTH-1:0] cp1;
    logic [WIDTH:0]   c0;
    logic [WIDTH:0]   c1;
    logic [WIDTH:0]   s0;
    logic [WIDTH:0]   s1;

    // Unmasked carry-in enters as share 0 with a zero share 1.
    assign c0[0] = bus.c_in;
    assign c1[0] = 1'b0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign p0[i] = a0[i] ^ b0[i];
        assign p1[i] = a1[i] ^ b1[i];

        // The cross terms are blinded by r before they meet the
        // same-domain term, so no wire ever carries a0&b1^a1&b0.
        assign ab0[i] = (a0[i] & b0[i])
                      ^ ((a0[i] & b1[i]) ^ rnd[2*i]);
        assign ab1[i] = (a1[i] & b1[i])
                      ^ ((a1[i] & b0[i]) ^ rnd[2*i]);

        assign cp0[i] = (c0[i] & p0[i])
                      ^ ((c0[i] & p1[i]) ^ rnd[2*i+1]);
        assign cp1[i] = (c1[i] & p1[i])
                      ^ ((c1[i] & p0[i]) ^ rnd[2*i+1]);

        // a&b and c&p are never both 1, so XOR equals OR here.
        assign c0[i+1] = ab0[i] ^ cp0[i];
        assign c1[i+1] = ab1[i] ^ cp1[i];

        assign s0[i] = p0[i] ^ c0[i];
        assign s1[i] = p1[i] ^ c1[i];
    end

    assign s0[WIDTH] = c0[WIDTH];
    assign s1[WIDTH] = c1[WIDTH];

    // Shares meet only here, right at the register input.
    logic [WIDTH:0] sum_d;
    assign sum_d = s0 ^ s1;

    logic [WIDTH:0] sum_q;
    logic           valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                sum_q <= sum_d;
            end
        end
    end

    assign bus.sum       = sum_q;
    assign bus.out_valid = valid_q;

`ifdef MASKED_SHARES_OUT_EN
    logic [WIDTH:0] sum_s0_q;
    logic [WIDTH:0] sum_s1_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_s0_q <= '0;
            sum_s1_q <= '0;
        end else if (bus.in_valid) begin
            sum_s0_q <= s0;
            sum_s1_q <= s1;
        end
    end

    assign bus.sum_s0 = sum_s0_q;
    assign bus.sum_s1 = sum_s1_q;
`endif

endmodule

// File: tb/tb_masked_rca.sv
// tb_masked_rca: scoreboard bench for masked_rca.
// Expected sums are queued when operands are driven, checked on out_valid.
module tb_masked_rca;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    masked_rca_if #(.WIDTH(4)) bus ();

    masked_rca #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int vectors = 0;
    int miscompares = 0;

    logic [4:0] q[$];
    logic [4:0] mon_exp;
    logic [4:0] last_exp = '0;

    // Scoreboard monitor: every out_valid cycle must match the queue head.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid) begin
            vectors++;
            if (q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_out: sum=%h with empty queue",
                         bus.sum);
            end else begin
                mon_exp = q.pop_front();
                if (bus.sum !== mon_exp) begin
                    miscompares++;
                    $display("FAIL sum: got %h want %h",
                             bus.sum, mon_exp);
                end
`ifdef MASKED_SHARES_OUT_EN
                vectors++;
                if ((bus.sum_s0 ^ bus.sum_s1) !== mon_exp) begin
                    miscompares++;
                    $display("FAIL shares_xor: got %h want %h",
                             bus.sum_s0 ^ bus.sum_s1, mon_exp);
                end
`endif
            end
        end
    end

    task automatic drive(input logic [3:0] xa0, input logic [3:0] xa1,
                         input logic [3:0] xb0, input logic [3:0] xb1,
                         input logic ci, input logic [7:0] r,
                         input logic [4:0] exp);
        bus.in_valid = 1'b1;
        bus.a0 = xa0;
        bus.a1 = xa1;
        bus.b0 = xb0;
        bus.b1 = xb1;
        bus.c_in = ci;
        bus.rnd = r;
        q.push_back(exp);
        last_exp = exp;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b1;
        bus.a0 = 4'hF;
        bus.a1 = 4'h3;
        bus.b0 = 4'h9;
        bus.b1 = 4'h1;
        bus.c_in = 1'b1;
        bus.rnd = 8'hA5;
        repeat (3) begin
            @(negedge clk);
            vectors++;
            if (bus.sum !== 5'h00 || bus.out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_hold: sum=%h ov=%b want 00/0",
                         bus.sum, bus.out_valid);
            end
        end
        bus.in_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if (bus.sum !== 5'h00 || bus.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release: sum=%h ov=%b want 00/0",
                     bus.sum, bus.out_valid);
        end
    endtask

    task automatic test_basic();
        drive(4'h0, 4'h1, 4'h2, 4'h4, 1'b0, 8'h00, 5'd7);
        drive(4'h1, 4'h2, 4'h3, 4'h5, 1'b1, 8'h00, 5'd10);
        idle();
    endtask

    task automatic test_carry();
        drive(4'hF, 4'h0, 4'hA, 4'h5, 1'b1, 8'h00, 5'h1F);
        drive(4'hF, 4'h0, 4'hA, 4'h5, 1'b0, 8'h00, 5'h1E);
        idle();
    endtask

    task automatic test_rnd_indep();
        logic [7:0] rv;
        for (int k = 0; k < 2; k++) begin
            rv = (k == 0) ? 8'hFF : 8'($urandom);
            drive(4'h0, 4'h1, 4'h2, 4'h4, 1'b0, rv, 5'd7);
            drive(4'h1, 4'h2, 4'h3, 4'h5, 1'b1, rv, 5'd10);
            drive(4'hF, 4'h0, 4'hA, 4'h5, 1'b1, rv, 5'h1F);
            drive(4'hF, 4'h0, 4'hA, 4'h5, 1'b0, rv, 5'h1E);
        end
        idle();
`ifdef MASKED_SHARES_OUT_EN
        begin
            logic [4:0] sh_a;
            drive(4'h1, 4'h2, 4'h3, 4'h5, 1'b1, 8'h00, 5'd10);
            sh_a = bus.sum_s0;
            drive(4'h1, 4'h2, 4'h3, 4'h5, 1'b1, 8'h01, 5'd10);
            vectors++;
            if (bus.sum_s0 === sh_a) begin
                miscompares++;
                $display("FAIL share_refresh: s0=%h unchanged", sh_a);
            end
            idle();
        end
`endif
    endtask

    task automatic test_back_to_back();
        logic [3:0] x;
        logic [4:0] e;
        for (int i = 0; i < 16; i++) begin
            x = 4'(i);
            e = {1'b0, x ^ (x + 4'd1)}
              + {1'b0, (x + 4'd2) ^ (x + 4'd3)}
              + {4'b0, x[0]};
            drive(x, x + 4'd1, x + 4'd2, x + 4'd3, x[0],
                  8'($urandom), e);
        end
        for (int i = 0; i < 3; i++) begin
            idle();
            vectors++;
            if (bus.sum !== last_exp || bus.out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL hold: sum=%h ov=%b want %h/0",
                         bus.sum, bus.out_valid, last_exp);
            end
        end
    endtask

    task automatic test_reset_midstream();
        drive(4'h3, 4'h0, 4'h4, 4'h0, 1'b0, 8'h00, 5'd7);
        @(negedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.a0 = 4'hC;
        bus.b0 = 4'h2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (bus.sum !== 5'h00 || bus.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_async: sum=%h ov=%b want 00/0",
                     bus.sum, bus.out_valid);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (bus.sum !== 5'h00 || bus.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_drop: sum=%h ov=%b want 00/0",
                     bus.sum, bus.out_valid);
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if (bus.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_release: ov=%b want 0",
                     bus.out_valid);
        end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.a0 = '0;
        bus.a1 = '0;
        bus.b0 = '0;
        bus.b1 = '0;
        bus.c_in = 1'b0;
        bus.rnd = '0;
        test_reset();
        test_basic();
        test_carry();
        test_rnd_indep();
        test_back_to_back();
        test_reset_midstream();
        repeat (2) @(posedge clk);
        vectors++;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d results never seen, want 0",
                     q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/masked_rca.md
Name: masked_rca

Overview:
- WIDTH-bit ripple-carry adder whose operands arrive as two Boolean (XOR) shares each: a = a0^a1, b = b0^b1.
- Addition is computed share-wise, with fresh randomness refreshing every nonlinear (AND) term, so no internal wire carries an unmasked operand bit.
- The recombined (WIDTH+1)-bit sum is registered once.
- Sits in a masked datapath, e.g. a side-channel-hardened crypto or arithmetic unit.

Parameters:
- WIDTH, 4, operand width in bits; sum is WIDTH+1 bits.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands, c_in and rnd are valid this cycle.
- a0  input  WIDTH  share 0 of operand a.
- a1  input  WIDTH  share 1 of operand a.
- b0  input  WIDTH  share 0 of operand b.
- b1  input  WIDTH  share 1 of operand b.
- c_in  input  1  carry-in, unmasked (treated as share0=c_in, share1=0).
- rnd  input  2*WIDTH  fresh random bits, two per bit position.
- sum  output  WIDTH+1  registered result (a + b + c_in), MSB = carry-out.
- out_valid  output  1  sum holds a new result.

Behaviour:
- Reset: rst_n low asynchronously clears sum to 0 and out_valid to 0, regardless of clk. Release takes effect on the next rising clk edge.
- Per bit i, share-wise full adder with carry shares c0/c1 (c0[0]=c_in, c1[0]=0):
  - p_s = a_s[i]^b_s[i]
  - sum share s_s = p_s^c_s[i]
  - carry = (a&b) ^ (c&p)
- Each masked AND x&y uses the ISW/DOM form:
  - z0 = (x0&y0) ^ (x0&y1 ^ r)
  - z1 = (x1&y1) ^ (x1&y0 ^ r)
- Random-bit allocation: a&b uses rnd[2i]; c&p uses rnd[2i+1].
- Carry shares propagate to bit i+1. Final carry shares form sum share bit WIDTH.
- Output stage:
  - Shares are recombined (sum = S0^S1) only at the register input.
  - Registered on the rising clk edge when in_valid=1. Latency 1 cycle.
  - out_valid <= in_valid every cycle.
  - When in_valid=0, sum holds its previous value.
- Arithmetic:
  - Unsigned, no saturation.
  - Overflow appears in sum[WIDTH]. Max a=b=2^WIDTH-1 with c_in=1 gives 2^(WIDTH+1)-1.
- The result must be independent of the rnd value; rnd affects only internal share values.
- Back-to-back in_valid accepted every cycle with no bubbles.
- Reset asserted mid-stream: the result in flight is discarded and out_valid reads 0.

Optional Feature:
- Macro: MASKED_SHARES_OUT_EN.
- When defined: adds output ports sum_s0 and sum_s1 (WIDTH+1 each). They are registered alongside sum and reset to 0, with sum_s0^sum_s1 == sum. This keeps the result masked for downstream logic.
- When undefined: those ports and their registers do not exist; only the recombined sum is produced.

Test Plan:
- Reset: rst_n=0 with in_valid=1 and nonzero inputs -> sum=0, out_valid=0, holding even while clk toggles.
- a0=0,a1=1,b0=2,b1=4,c_in=0,rnd=0 (a=1,b=6), in_valid=1 -> next cycle sum=7, out_valid=1.
- a0=1,a1=2,b0=3,b1=5,c_in=1 (a=3,b=6) -> sum=10.
- Carry-out: a0=4'hF,a1=0,b0=4'hA,b1=4'h5 (b=15), c_in=1 -> sum=5'h1F. Same with c_in=0 -> 5'h1E.
- Randomness independence: repeat each case above with rnd=8'hFF and with random rnd -> identical sum. Under MASKED_SHARES_OUT_EN, sum_s0/sum_s1 differ across rnd values but always XOR to sum.
- Stream of 16 consecutive in_valid cycles with all inputs incrementing by 1 each cycle (c_in toggling) -> each sum matches the golden model one cycle later. Then hold in_valid=0 -> sum holds the last value.
